// File: rtl/cla_add_pipe_if.sv
// Operand/result handshake bundle for cla_add_pipe.
// The adder is the slave; the producer/consumer side is the master.
interface cla_add_pipe_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cIn;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s;
  logic             cOut;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output x, y, cIn, sub, in_valid, out_ready,
    input  in_ready, s, cOut, ovf, out_valid
  );

  modport slave (
    input  x, y, cIn, sub, in_valid, out_ready,
    output in_ready, s, cOut, ovf, out_valid
  );
endinterface

// File: rtl/cla_add_pipe.sv
// Pipelined add/subtract: one BLK-bit carry-lookahead block per stage, operands skewed
// in and the result deskewed through a single per-stage shift register.

// BLK-bit Kogge-Stone carry-lookahead adder slice.
module cla_blk #(
  parameter int BLK = 16
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] sum,
  output logic           co
);
  logic [BLK-1:0] pBit;
  logic [BLK-1:0] gPre, pPre, gNxt, pNxt;
  logic [BLK:0]   cy;

  assign pBit = a ^ b;

  // After the prefix tree gPre[i]/pPre[i] are the group terms over bits [i:0].
  always_comb begin
    gPre = a & b;
    pPre = pBit;
    gNxt = '0;
    pNxt = '0;
    for (int d = 1; d < BLK; d = d * 2) begin
      gNxt = gPre;
      pNxt = pPre;
      for (int i = d; i < BLK; i++) begin
        gNxt[i] = gPre[i] | (pPre[i] & gPre[i-d]);
        pNxt[i] = pPre[i] & pPre[i-d];
      end
      gPre = gNxt;
      pPre = pNxt;
    end
  end

  assign cy  = {gPre | (pPre & {BLK{ci}}), ci};
  assign sum = pBit ^ cy[BLK-1:0];
  assign co  = cy[BLK];
endmodule

module cla_add_pipe #(
  parameter int WIDTH = 64,
  parameter int BLK   = 16
) (
  input  logic          clk,
  input  logic          rst,
  cla_add_pipe_if.slave bus
);
  localparam int NSTG = (BLK > 0) ? WIDTH / BLK : 1;

  if ((BLK < 1) || (WIDTH < BLK) || ((WIDTH % BLK) != 0)) begin : gBadCfg
    $error("cla_add_pipe: WIDTH (%0d) must be a positive multiple of BLK (%0d)", WIDTH, BLK);
  end

  // x holds unconsumed operand slices in its low part and finished sum slices
  // in its high part; y shifts down so the live slice is always at [BLK-1:0].
  typedef struct packed {
    logic             vld;
    logic             c;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } stg_t;

  stg_t             stQ [NSTG];
  logic             adv;
  logic             outVld;
  logic [WIDTH-1:0] sReg;
  logic             cOutReg;
  logic             ovfReg;

  assign adv          = !outVld || bus.out_ready;
  assign bus.in_ready = adv;

  assign stQ[0] = '{vld: bus.in_valid,
                    c:   bus.sub | bus.cIn,
                    x:   bus.x,
                    y:   bus.sub ? ~bus.y : bus.y};

  for (genvar k = 0; k < NSTG; k++) begin : gStg
    stg_t             cur;
    logic [BLK-1:0]   bSum;
    logic             bCo;
    logic [WIDTH-1:0] nxtX;

    assign cur = stQ[k];

    cla_blk #(.BLK(BLK)) uBlk (
      .a   (cur.x[BLK-1:0]),
      .b   (cur.y[BLK-1:0]),
      .ci  (cur.c),
      .sum (bSum),
      .co  (bCo)
    );

    assign nxtX = (cur.x >> BLK) | (WIDTH'(bSum) << (WIDTH - BLK));

    if (k < NSTG - 1) begin : gMid
      stg_t q;
      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else if (adv) begin
          q.vld <= cur.vld;
          if (cur.vld) begin
            q.c <= bCo;
            q.x <= nxtX;
            q.y <= cur.y >> BLK;
          end
        end
      end
      assign stQ[k+1] = q;
    end else begin : gOut
      // The last slice carries both operand sign bits, so overflow resolves here.
      always_ff @(posedge clk) begin
        if (rst) begin
          outVld  <= 1'b0;
          sReg    <= '0;
          cOutReg <= 1'b0;
          ovfReg  <= 1'b0;
        end else if (adv) begin
          outVld <= cur.vld;
          if (cur.vld) begin
            sReg    <= nxtX;
            cOutReg <= bCo;
            ovfReg  <= (cur.x[BLK-1] == cur.y[BLK-1]) && (bSum[BLK-1] != cur.x[BLK-1]);
          end
        end
      end
    end
  end

  assign bus.s         = sReg;
  assign bus.cOut      = cOutReg;
  assign bus.ovf       = ovfReg;
  assign bus.out_valid = outVld;
endmodule

// File: tb/tb_cla_add_pipe.sv
// Randomized check of cla_add_pipe (64/16) against an arithmetic reference scoreboard.
module tb_cla_add_pipe;
  localparam int W  = 64;
  localparam int B  = 16;
  localparam int NS = W / B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_add_pipe_if #(.WIDTH(W)) bus ();
  cla_add_pipe #(.WIDTH(W), .BLK(B)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   nVec = 0;
  int   nErr = 0;
  int   cyc  = 0;
  int   nOut = 0;
  bit   strict = 1'b1;
  bit   ovHist [0:8191];

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic ci, logic md, int at);
    exp_t              e;
    logic [W:0]        u;
    logic signed [W+1:0] sa, sb2, sv, sr;
    sa  = $signed({{2{a[W-1]}}, a});
    sb2 = $signed({{2{b[W-1]}}, b});
    if (!md) begin
      u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      sv = sa + sb2 + $signed({{(W+1){1'b0}}, ci});
    end else begin
      u    = {1'b0, a} - {1'b0, b};
      u[W] = (a >= b);
      sv   = sa - sb2;
    end
    e.s   = u[W-1:0];
    e.c   = u[W];
    sr    = $signed({{2{u[W-1]}}, u[W-1:0]});
    e.ov  = (sv != sr);
    e.acc = at;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(0, 9))
      0:       return {W{1'b1}};
      1:       return '0;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: accepts push, consumes pop, reset flushes in-flight work.
  initial begin
    exp_t         e;
    bit           holdChk;
    logic [W-1:0] heldS;
    holdChk = 1'b0;
    heldS   = '0;
    forever begin
      @(negedge clk);
      ovHist[cyc[12:0]] = bus.out_valid;
      if (rst) begin
        sb.delete();
        holdChk = 1'b0;
      end else begin
        if (holdChk) begin
          chk("hold_vld", bus.out_valid, 1'b1);
          chk("hold_s", bus.s, heldS);
        end
        holdChk = bus.out_valid && !bus.out_ready;
        heldS   = bus.s;
        chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexp_out", bus.out_valid, 1'b0);
          end else begin
            e = sb.pop_front();
            chk("s", bus.s, e.s);
            chk("cOut", bus.cOut, e.c);
            chk("ovf", bus.ovf, e.ov);
            if (strict) chk("latency", cyc - e.acc, NS);
            nOut++;
          end
        end
        if (bus.in_valid && bus.in_ready)
          sb.push_back(model(bus.x, bus.y, bus.cIn, bus.sub, cyc));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic ci, logic md);
    int t;
    t = 0;
    bus.x = a; bus.y = b; bus.cIn = ci; bus.sub = md; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("send_timeout", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitOut(string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_vld"}, bus.out_valid, 1'b1);
  endtask

  task automatic drain(string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, seen, c0;
    bit took;
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0, seen, c0;
    bit  took;
    bus.x = '0; bus.y = '0; bus.cIn = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", bus.out_valid, 1'b0);
    chk("rst_s", bus.s, '0);
    chk("rst_cOut", bus.cOut, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_rdy", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // carry ripples through every block
    send({W{1'b1}}, '0, 1'b1, 1'b0);
    waitOut("ripple");
    chk("ripple_s", bus.s, '0);
    chk("ripple_cOut", bus.cOut, 1'b1);
    chk("ripple_ovf", bus.ovf, 1'b0);
    @(posedge clk); #1;

    // signed overflow, add then subtract
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    waitOut("ovfadd");
    chk("ovfadd_s", bus.s, 64'h8000_0000_0000_0000);
    chk("ovfadd_cOut", bus.cOut, 1'b0);
    chk("ovfadd_ovf", bus.ovf, 1'b1);
    @(posedge clk); #1;
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    waitOut("ovfsub");
    chk("ovfsub_s", bus.s, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("ovfsub_cOut", bus.cOut, 1'b1);
    chk("ovfsub_ovf", bus.ovf, 1'b1);
    @(posedge clk); #1;
    drain("directed");

    // 100 back-to-back, mixed modes
    n0 = nOut;
    for (int i = 0; i < 100; i++)
      send(rnd64(), rnd64(), 1'($urandom), 1'($urandom));
    drain("stream");
    chk("stream_cnt", nOut - n0, 100);

    // 6-cycle backpressure while streaming
    strict = 1'b0;
    n0 = nOut;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(rnd64(), rnd64(), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (8) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_rdy", bus.in_ready, 1'b0);
        chk("bp_vld", bus.out_valid, 1'b1);
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("bp");
    chk("bp_cnt", nOut - n0, 30);
    strict = 1'b1;

    // reset with 3 in flight; input presented during reset must be dropped
    send(rnd64(), rnd64(), 1'b1, 1'b0);
    send(rnd64(), rnd64(), 1'b0, 1'b1);
    send(rnd64(), rnd64(), 1'b1, 1'b1);
    rst = 1'b1;
    bus.x = rnd64(); bus.y = rnd64(); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", bus.out_valid, 1'b0);
    chk("mid_rst_s", bus.s, '0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen += int'(bus.out_valid);
    end
    chk("mid_rst_none", seen, 0);
    @(posedge clk); #1;

    // bubbles 1,0,1,0 come out as 1,0,1,0
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      bus.x = rnd64(); bus.y = rnd64(); bus.cIn = 1'($urandom); bus.sub = 1'($urandom);
      bus.in_valid = (i % 2 == 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain("bubble");
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      chk("bubble_pat", ovHist[13'(c0 + NS + i)], (i % 2 == 0) && (i < 4));

    // random valid/ready traffic; source holds while stalled
    strict = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (!bus.in_valid || took) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.x = rnd64(); bus.y = rnd64();
        bus.cIn = 1'($urandom); bus.sub = 1'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/cla_add_pipe.md
CLA_ADD_PIPE -- requirements
Module: cla_add_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, total operand width in bits.
REQ-002 The block SHALL have parameter BLK, default 16, carry-lookahead block width and bits summed per pipeline stage.
REQ-003 The block SHALL treat NSTG = WIDTH/BLK as the derived stage count; WIDTH not a positive multiple of BLK SHALL be an elaboration error.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 x  input  WIDTH  operand A.
REQ-007 y  input  WIDTH  operand B.
REQ-008 cIn  input  1  carry-in, used only when sub=0.
REQ-009 sub  input  1  mode: 0 = add, 1 = subtract (x - y).
REQ-010 in_valid  input  1  x, y, cIn and sub are valid this cycle.
REQ-011 in_ready  output  1  the block accepts input this cycle.
REQ-012 s  output  WIDTH  sum or difference.
REQ-013 cOut  output  1  carry-out of the MSB; in subtract mode 1 means no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 out_valid  output  1  s, cOut and ovf are valid.
REQ-016 out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-017 The block SHALL compute {cOut,s} = x + y + cIn when sub=0, and {cOut,s} = x + ~y + 1 when sub=1, modulo 2^(WIDTH+1).
REQ-018 The block SHALL set ovf = (xa[MSB] == ya[MSB]) && (s[MSB] != xa[MSB]), where xa = x and ya = y when sub=0, and ya = ~y when sub=1.
REQ-019 Stage k (0..NSTG-1) SHALL sum bits [k*BLK +: BLK] with BLK-bit carry-lookahead logic, taking the carry registered by stage k-1 (stage 0 takes the mode-selected carry-in); no carry chain SHALL span more than one block between registers.
REQ-020 Operand slices not yet consumed and result slices already produced SHALL travel with their transaction in per-stage registers (input skew, output deskew), so each transaction's s is presented coherently on a single cycle.
REQ-021 Each stage SHALL carry a valid bit; a bubble (in_valid=0) SHALL propagate as valid=0.
REQ-022 Latency SHALL be exactly NSTG cycles from the accepting edge (in_valid && in_ready) to out_valid=1 with no backpressure; throughput SHALL be one transaction per cycle.
REQ-023 The global advance enable SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-024 When adv=0, every stage register, valid bits included, SHALL hold its value; s, cOut, ovf and out_valid SHALL remain stable until accepted.
REQ-025 A result SHALL be consumed on an edge where out_valid && out_ready; with in_valid held at 1 the same edge SHALL accept a new input.
REQ-026 When in_valid=1 and in_ready=0, the input SHALL NOT be captured; the source holds it.
REQ-027 sub and cIn SHALL be sampled per transaction; consecutive transactions with different modes SHALL NOT interfere.
REQ-028 With NSTG=1 the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-029 On a clk edge with rst=1, all stage valid bits and out_valid SHALL clear to 0, and s, cOut and ovf SHALL clear to 0.
REQ-030 Reset mid-operation SHALL discard every in-flight transaction; no result from before reset SHALL appear afterwards.
REQ-031 During rst=1, in_ready SHALL follow REQ-023 (1 after the first reset edge), but no input SHALL be captured on a reset edge.

Verification (WIDTH=64, BLK=16, NSTG=4)
REQ-032 Carry ripple across all blocks: x=64'hFFFF_FFFF_FFFF_FFFF, y=0, cIn=1, sub=0 -> 4 cycles later s=0, cOut=1, ovf=0.
REQ-033 Signed overflow: x=64'h7FFF_FFFF_FFFF_FFFF, y=1, sub=0 -> s=64'h8000_0000_0000_0000, cOut=0, ovf=1; then x=64'h8000_0000_0000_0000, y=1, sub=1 -> s=64'h7FFF_FFFF_FFFF_FFFF, cOut=1, ovf=1.
REQ-034 Streaming: 100 back-to-back random transactions with mixed sub/cIn and out_ready=1 -> 100 results in order on 100 consecutive cycles, matching a reference model, with first out_valid 4 cycles after the first accept.
REQ-035 Backpressure: out_ready=0 for 6 cycles while streaming -> in_ready=0 from the first stalled cycle, s held stable, no loss or duplication after out_ready returns to 1.
REQ-036 Reset mid-flight: 3 transactions in flight, rst=1 for 1 cycle -> out_valid=0, s=0, and none of the 3 results ever appear.
REQ-037 Bubbles: in_valid pattern 1,0,1,0 -> out_valid pattern 1,0,1,0 starting 4 cycles later, with correct sums.
